ps2_lcd_line_buffer: RTL and testbench

//  Parametrised keystroke line buffer between PS2_controller and LCD_controller.
//  - Collects PS2 make codes, each tagged with a case flag, into a DEPTH-entry buffer; supports backspace.
//  - When the buffer is full, it streams the line to the LCD through the PS2-to-LCD ROM, then switches LCD line.
//  - Evaluates half-match and palindrome on each completed line. Also runs the LCD power-up init sequence.

---
 rtl/ps2_lcd_line_buffer.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_lcd_line_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_lcd_line_buffer.sv
// rtl/ps2_lcd_line_buffer.sv - PS2 keystroke line buffer that flushes full lines to the LCD via the char ROM
// Also runs the LCD power-up init sequence and judges half-match / palindrome per completed line.
module ps2_lcd_line_buffer #(
   parameter int         DEPTH       = 16,
   parameter int         ROM_LATENCY = 1,
   parameter logic [7:0] BKSP_CODE   = 8'h66
) (
   input  logic       Clock_50,
   input  logic       Reset,
   input  logic [7:0] PS2_code,
   input  logic       PS2_code_ready,
   input  logic       PS2_make_code,
   input  logic       case_flag,
   output logic [8:0] ROM_address,
   input  logic [7:0] ROM_q,
   output logic       LCD_start,
   output logic [8:0] LCD_instruction,
   input  logic       LCD_done,
   output logic [4:0] char_count,
   output logic       line_sel,
   output logic       half_match,
   output logic       palindrome,
   output logic       key_dropped
);

   localparam int             PW      = $clog2(DEPTH);
   localparam logic [PW-1:0]  LAST    = PW'(DEPTH - 1);
   localparam logic [4:0]     FULL_M1 = 5'(DEPTH - 1);
   localparam logic [1:0]     LAT_M1  = 2'(ROM_LATENCY - 1);

   typedef enum logic [2:0] {
      S_INIT, S_INIT_WAIT, S_IDLE, S_ROM_WAIT,
      S_ISSUE_CHAR, S_WAIT_CHAR, S_ISSUE_LINE, S_WAIT_LINE
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    init_idx_q, init_idx_d;
   logic [8:0]    buf_q [DEPTH];
   logic [8:0]    buf_d [DEPTH];
   logic [8:0]    push_buf [DEPTH];
   logic [4:0]    count_q, count_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [1:0]    lat_q, lat_d;
   logic          start_q, start_d;
   logic [8:0]    instr_q, instr_d;
   logic          line_sel_q, line_sel_d;
   logic          hm_q, hm_d;
   logic          pal_q, pal_d;
   logic          dropped_q, dropped_d;
   logic          ready_q;
   logic          key_ev, is_bksp, full_push, done_ok;
   logic          hm_calc, pal_calc;
   logic [PW-1:0] rom_idx;

   function automatic logic [8:0] init_word(input logic [2:0] idx);
      case (idx)
         3'd0:    return 9'h038;
         3'd1:    return 9'h00C;
         3'd2:    return 9'h001;
         3'd3:    return 9'h006;
         default: return 9'h080;
      endcase
   endfunction

   assign key_ev    = PS2_code_ready && !ready_q && PS2_make_code;
   assign is_bksp   = (PS2_code == BKSP_CODE);
   assign full_push = key_ev && !is_bksp && (count_q == FULL_M1);
   // A done seen while our own start is still high belongs to the previous command.
   assign done_ok   = LCD_done && !start_q;

   // Index 0 is the newest entry; the oldest full-line character sits at DEPTH-1.
   always_comb begin
      push_buf[0] = {case_flag, PS2_code};
      for (int i = 1; i < DEPTH; i++) push_buf[i] = buf_q[i-1];
   end

   always_comb begin
      hm_calc  = 1'b1;
      pal_calc = 1'b1;
      for (int i = 0; i < DEPTH/2; i++) begin
         if (push_buf[i][7:0] != push_buf[i+DEPTH/2][7:0]) hm_calc = 1'b0;
         if (push_buf[i][7:0] != push_buf[DEPTH-1-i][7:0]) pal_calc = 1'b0;
      end
   end

   always_ff @(posedge Clock_50) begin
      if (Reset) state_q <= S_INIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:       state_d = S_INIT_WAIT;
         S_INIT_WAIT:  if (done_ok) state_d = (init_idx_q < 3'd4) ? S_INIT : S_IDLE;
         S_IDLE:       if (full_push) state_d = S_ROM_WAIT;
         S_ROM_WAIT:   if (lat_q == LAT_M1) state_d = S_ISSUE_CHAR;
         S_ISSUE_CHAR: state_d = S_WAIT_CHAR;
         S_WAIT_CHAR:  if (done_ok) state_d = (ptr_q == LAST) ? S_ISSUE_LINE : S_ROM_WAIT;
         S_ISSUE_LINE: state_d = S_WAIT_LINE;
         S_WAIT_LINE:  if (done_ok) state_d = S_IDLE;
         default:      state_d = S_INIT;
      endcase
   end

   always_comb begin
      init_idx_d = init_idx_q;
      buf_d      = buf_q;
      count_d    = count_q;
      ptr_d      = ptr_q;
      lat_d      = lat_q;
      start_d    = 1'b0;
      instr_d    = instr_q;
      line_sel_d = line_sel_q;
      hm_d       = hm_q;
      pal_d      = pal_q;
      dropped_d  = key_ev && (state_q != S_IDLE);
      case (state_q)
         S_INIT: begin
            instr_d = init_word(init_idx_q);
            start_d = 1'b1;
         end
         S_INIT_WAIT: begin
            if (done_ok) init_idx_d = init_idx_q + 3'd1;
         end
         S_IDLE: begin
            if (key_ev && is_bksp) begin
               if (count_q != 5'd0) begin
                  for (int i = 0; i < DEPTH-1; i++) buf_d[i] = buf_q[i+1];
                  buf_d[DEPTH-1] = 9'h000;
                  count_d = count_q - 5'd1;
               end
            end else if (key_ev) begin
               buf_d   = push_buf;
               count_d = count_q + 5'd1;
               if (full_push) begin
                  hm_d  = hm_calc;
                  pal_d = pal_calc;
                  ptr_d = '0;
                  lat_d = 2'd0;
               end
            end
         end
         S_ROM_WAIT: lat_d = lat_q + 2'd1;
         S_ISSUE_CHAR: begin
            instr_d = {1'b1, ROM_q};
            start_d = 1'b1;
         end
         S_WAIT_CHAR: begin
            if (done_ok && ptr_q != LAST) begin
               ptr_d = ptr_q + 1'b1;
               lat_d = 2'd0;
            end
         end
         S_ISSUE_LINE: begin
            instr_d    = {2'b01, ~line_sel_q, 6'h00};
            start_d    = 1'b1;
            line_sel_d = ~line_sel_q;
         end
         S_WAIT_LINE: begin
            if (done_ok) begin
               for (int i = 0; i < DEPTH; i++) buf_d[i] = 9'h000;
               count_d = 5'd0;
               ptr_d   = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         init_idx_q <= 3'd0;
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= 9'h000;
         count_q    <= 5'd0;
         ptr_q      <= '0;
         lat_q      <= 2'd0;
         start_q    <= 1'b0;
         instr_q    <= 9'h000;
         line_sel_q <= 1'b0;
         hm_q       <= 1'b0;
         pal_q      <= 1'b0;
         dropped_q  <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         init_idx_q <= init_idx_d;
         buf_q      <= buf_d;
         count_q    <= count_d;
         ptr_q      <= ptr_d;
         lat_q      <= lat_d;
         start_q    <= start_d;
         instr_q    <= instr_d;
         line_sel_q <= line_sel_d;
         hm_q       <= hm_d;
         pal_q      <= pal_d;
         dropped_q  <= dropped_d;
         ready_q    <= PS2_code_ready;
      end
   end

   assign rom_idx         = LAST - ptr_q;
   assign ROM_address     = buf_q[rom_idx];
   assign LCD_start       = start_q;
   assign LCD_instruction = instr_q;
   assign char_count      = count_q;
   assign line_sel        = line_sel_q;
   assign half_match      = hm_q;
   assign palindrome      = pal_q;
   assign key_dropped     = dropped_q;

endmodule

// File: tb/tb_ps2_lcd_line_buffer.sv
// tb/tb_ps2_lcd_line_buffer.sv - scoreboard bench for ps2_lcd_line_buffer with LCD and ROM models
module tb_ps2_lcd_line_buffer;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] PS2_code = 8'h00;
   logic       PS2_code_ready = 1'b0;
   logic       PS2_make_code = 1'b0;
   logic       case_flag = 1'b0;
   logic [8:0] ROM_address;
   logic [7:0] ROM_q = 8'h00;
   logic       LCD_start;
   logic [8:0] LCD_instruction;
   logic       LCD_done = 1'b0;
   logic [4:0] char_count;
   logic       line_sel, half_match, palindrome, key_dropped;

   always #5 clk = ~clk;

   ps2_lcd_line_buffer #(.DEPTH(16), .ROM_LATENCY(1), .BKSP_CODE(8'h66)) dut (
      .Clock_50(clk), .Reset(Reset), .PS2_code(PS2_code), .PS2_code_ready(PS2_code_ready),
      .PS2_make_code(PS2_make_code), .case_flag(case_flag), .ROM_address(ROM_address),
      .ROM_q(ROM_q), .LCD_start(LCD_start), .LCD_instruction(LCD_instruction),
      .LCD_done(LCD_done), .char_count(char_count), .line_sel(line_sel),
      .half_match(half_match), .palindrome(palindrome), .key_dropped(key_dropped)
   );

   int         total = 0;
   int         bad = 0;
   int         n_start = 0;
   int         n_drop = 0;
   int         lcd_cnt = 0;
   logic       prev_start = 1'b0;
   logic [8:0] sb [$];
   logic [8:0] model [$];
   logic       exp_line = 1'b0;
   logic       exp_hm = 1'b0;
   logic       exp_pal = 1'b0;
   logic [7:0] alpha [16] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                              8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D};
   logic [7:0] pal8 [8]   = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h23, 8'h21, 8'h32, 8'h1C};

   function automatic logic [7:0] rom_f(input logic [8:0] a);
      return a[7:0] ^ (a[8] ? 8'h20 : 8'h00) ^ 8'h01;
   endfunction

   // ROM model, LCD controller model (done 5 cycles after start) and instruction scoreboard
   always @(negedge clk) begin
      logic [8:0] exp;
      ROM_q = rom_f(ROM_address);
      LCD_done = 1'b0;
      if (lcd_cnt > 0) begin
         lcd_cnt--;
         if (lcd_cnt == 0) LCD_done = 1'b1;
      end
      if (!Reset) begin
         if (key_dropped) n_drop++;
         if (LCD_start) begin
            n_start++;
            total++;
            if (prev_start) begin
               bad++;
               $display("FAIL start_width got=2-cycle want=1-cycle");
            end
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_instr got=%03h want=none", LCD_instruction);
            end else begin
               exp = sb.pop_front();
               if (LCD_instruction !== exp) begin
                  bad++;
                  $display("FAIL lcd_instr got=%03h want=%03h", LCD_instruction, exp);
               end
            end
            lcd_cnt = 5;
         end
      end
      prev_start = LCD_start;
   end

   task automatic push_init();
      sb.push_back(9'h038); sb.push_back(9'h00C); sb.push_back(9'h001);
      sb.push_back(9'h006); sb.push_back(9'h080);
   endtask

   task automatic drive_key(input logic [7:0] code, input logic flag);
      @(negedge clk);
      PS2_code = code; case_flag = flag; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
      @(negedge clk);
      PS2_code_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic type_key(input logic [7:0] code, input logic flag);
      if (code == 8'h66) begin
         if (model.size() > 0) void'(model.pop_back());
      end else begin
         model.push_back({flag, code});
         if (model.size() == 16) begin
            exp_hm = 1'b1; exp_pal = 1'b1;
            for (int k = 0; k < 8; k++) begin
               if (model[k][7:0] != model[k+8][7:0]) exp_hm = 1'b0;
               if (model[k][7:0] != model[15-k][7:0]) exp_pal = 1'b0;
            end
            for (int k = 0; k < 16; k++) sb.push_back({1'b1, rom_f(model[k])});
            sb.push_back(exp_line ? 9'h080 : 9'h0C0);
            exp_line = ~exp_line;
            model.delete();
         end
      end
      drive_key(code, flag);
   endtask

   task automatic wait_drain(input string name);
      int i = 0;
      while ((sb.size() != 0 || char_count != 5'd0) && i < 3000) begin
         @(negedge clk);
         i++;
      end
      total++;
      if (i >= 3000) begin
         bad++;
         $display("FAIL %s_timeout got=%0d_pending want=0", name, sb.size());
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({LCD_start, LCD_instruction, ROM_address, char_count} !== 24'h0) begin
         bad++;
         $display("FAIL reset_lcd got=%0h want=0", {LCD_start, LCD_instruction, ROM_address, char_count});
      end
      total++;
      if ({line_sel, half_match, palindrome, key_dropped} !== 4'h0) begin
         bad++;
         $display("FAIL reset_flags got=%0h want=0", {line_sel, half_match, palindrome, key_dropped});
      end
      push_init();
      n_start = 0;
      Reset = 1'b0;
      wait_drain("init");
      total++;
      if (n_start != 5) begin
         bad++;
         $display("FAIL init_starts got=%0d want=5", n_start);
      end
   endtask

   task automatic test_full_line();
      for (int i = 0; i < 16; i++) begin
         type_key(alpha[i], 1'b0);
         if (i == 14) begin
            total++;
            if (char_count !== 5'd15) begin
               bad++;
               $display("FAIL line_count15 got=%0d want=15", char_count);
            end
         end
      end
      wait_drain("line");
      total++;
      if (line_sel !== 1'b1 || char_count !== 5'd0) begin
         bad++;
         $display("FAIL line_after got=%0b/%0d want=1/0", line_sel, char_count);
      end
      total++;
      if (half_match !== exp_hm || palindrome !== exp_pal) begin
         bad++;
         $display("FAIL line_cmp got=%0b%0b want=%0b%0b", half_match, palindrome, exp_hm, exp_pal);
      end
   endtask

   task automatic test_backspace();
      type_key(8'h66, 1'b0);
      total++;
      if (char_count !== 5'd0) begin
         bad++;
         $display("FAIL bksp_empty got=%0d want=0", char_count);
      end
      type_key(8'h1C, 1'b1);
      type_key(8'h66, 1'b0);
      type_key(8'h32, 1'b0);
      total++;
      if (char_count !== 5'd1) begin
         bad++;
         $display("FAIL bksp_count got=%0d want=1", char_count);
      end
      for (int i = 1; i < 16; i++) type_key(alpha[i], i[0]);
      wait_drain("bksp");
      total++;
      if (line_sel !== 1'b0) begin
         bad++;
         $display("FAIL bksp_line got=%0b want=0", line_sel);
      end
   endtask

   task automatic test_compare();
      for (int i = 0; i < 16; i++) type_key(pal8[i % 8], 1'b0);
      wait_drain("pal");
      total++;
      if (half_match !== 1'b1 || palindrome !== 1'b1) begin
         bad++;
         $display("FAIL pal_line got=%0b%0b want=11", half_match, palindrome);
      end
      type_key(8'h24, 1'b0);
      total++;
      if (half_match !== 1'b1 || palindrome !== 1'b1 || char_count !== 5'd1) begin
         bad++;
         $display("FAIL cmp_hold got=%0b%0b/%0d want=11/1", half_match, palindrome, char_count);
      end
      type_key(8'h66, 1'b0);
      for (int i = 0; i < 16; i++) type_key(alpha[i % 8], (i >= 8));
      wait_drain("half");
      total++;
      if (half_match !== 1'b1 || palindrome !== 1'b0) begin
         bad++;
         $display("FAIL half_line got=%0b%0b want=10", half_match, palindrome);
      end
   endtask

   task automatic test_drop();
      int i = 0;
      int base;
      for (int k = 0; k < 16; k++) type_key(alpha[15-k], 1'b0);
      while (!LCD_start && i < 200) begin
         @(negedge clk);
         i++;
      end
      total++;
      if (i >= 200) begin
         bad++;
         $display("FAIL drop_nostart got=none want=start");
      end
      @(negedge clk);
      base = n_drop;
      drive_key(8'h1C, 1'b0);
      repeat (3) @(negedge clk);
      total++;
      if (n_drop != base + 1) begin
         bad++;
         $display("FAIL drop_pulse got=%0d want=%0d", n_drop - base, 1);
      end
      wait_drain("drop");
      total++;
      if (char_count !== 5'd0) begin
         bad++;
         $display("FAIL drop_count got=%0d want=0", char_count);
      end
   endtask

   task automatic test_reset_mid();
      int i = 0;
      for (int k = 0; k < 16; k++) type_key(alpha[k], 1'b1);
      while (!LCD_start && i < 200) begin
         @(negedge clk);
         i++;
      end
      @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      total++;
      if ({LCD_start, LCD_instruction, ROM_address, char_count, line_sel, half_match, palindrome, key_dropped} !== 28'h0) begin
         bad++;
         $display("FAIL midreset_outs got=%0h want=0",
                  {LCD_start, LCD_instruction, ROM_address, char_count, line_sel, half_match, palindrome, key_dropped});
      end
      sb.delete();
      model.delete();
      exp_line = 1'b0; exp_hm = 1'b0; exp_pal = 1'b0;
      repeat (8) @(negedge clk);
      push_init();
      n_start = 0;
      Reset = 1'b0;
      wait_drain("reinit");
      total++;
      if (n_start != 5) begin
         bad++;
         $display("FAIL reinit_starts got=%0d want=5", n_start);
      end
      type_key(8'h1C, 1'b0);
      total++;
      if (char_count !== 5'd1) begin
         bad++;
         $display("FAIL reinit_type got=%0d want=1", char_count);
      end
   endtask

   initial begin
      test_reset();
      test_full_line();
      test_backspace();
      test_compare();
      test_drop();
      test_reset_mid();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
